sync_fifo_prog: RTL

- Parametrised synchronous single-clock FIFO with full-depth occupancy, registered read port, binary occupancy count and runtime-programmable almost-full/almost-empty thresholds.
- Used between pipeline stages (command/pixel streams) where producer and consumer share clk and need early back-pressure at a software-chosen level.

---
 rtl/sync_fifo_prog.sv | 118 +++++++++++
 1 files changed

// File: rtl/sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_prog
// Brief    : Single-clock FIFO with registered read port, occupancy count and
//            programmable almost-full/almost-empty thresholds. Optional sticky
//            overflow/underflow flags under SYNC_FIFO_PROG_ERR_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_prog #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  rvalid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] c_depth = FIFO_DEPTH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_read_data;
    logic                  r_rvalid;
    logic                  w_renq;
    logic                  w_wenq;

    assign empty        = (r_count == '0);
    assign full         = (r_count == c_depth);
    assign almost_full  = (r_count >= af_thresh);
    assign almost_empty = (r_count <= ae_thresh);
    assign count        = r_count;
    assign read_data    = r_read_data;
    assign rvalid       = r_rvalid;

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign w_renq = ren & ~empty;
    assign w_wenq = wen & (~full | w_renq);

    always_ff @(posedge clk) begin
        if (!reset && w_wenq) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_read_data <= '0;
            r_rvalid    <= 1'b0;
        end else begin
            if (w_wenq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_renq) begin
                r_read_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_rvalid    <= 1'b1;
            end else begin
                r_rvalid    <= 1'b0;
            end
            case ({w_wenq, w_renq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SYNC_FIFO_PROG_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Clear beats a same-cycle set so software never loses a clear.
    always_ff @(posedge clk) begin
        if (reset || err_clr) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wen && !w_wenq) begin
                r_overflow <= 1'b1;
            end
            if (ren && empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = err_clr;
    assign overflow         = 1'b0;
    assign underflow        = 1'b0;
`endif

endmodule
`default_nettype wire
